// File: rtl/ca_pkg.sv
// Shared constants and FSM encoding for the frame buffer and its write controller.
package ca_pkg;

  localparam int CA_COLS = 80;
  localparam int CA_ROWS = 60;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_CLEAR = 2'd2
  } fb_state_t;

  // Address width for n entries, never narrower than one bit.
  function automatic int addr_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fb_wr_ctrl.sv
// Write-side control for frame_buffer: read/write collision deferral,
// out-of-range drop, and the full-frame clear sweep.
module fb_wr_ctrl
  import ca_pkg::*;
#(
  parameter int COLS = CA_COLS,
  parameter int ROWS = CA_ROWS,
  parameter int RAW  = addr_w(CA_ROWS)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [RAW-1:0]  rd_row,
  input  logic [RAW-1:0]  alt_row,
  input  logic            wr_valid,
  input  logic [RAW-1:0]  wr_row,
  input  logic [COLS-1:0] wr_data,
  input  logic            clr_start,
  output logic            wr_ready,
  output logic            wr_err,
  output logic            clr_busy,
  output logic            mem_we,
  output logic [RAW-1:0]  mem_waddr,
  output logic [COLS-1:0] mem_wdata
);

  localparam logic [RAW:0]   ROWS_L   = (RAW+1)'(ROWS);
  localparam logic [RAW-1:0] LAST_ROW = RAW'(ROWS - 1);

  fb_state_t       state_reg;
  logic [RAW-1:0]  pend_row_reg;
  logic [COLS-1:0] pend_data_reg;
  logic [RAW-1:0]  sweep_reg;
  logic            wr_err_reg;
  logic            clr_busy_reg;

  logic accept;
  logic wr_in_range;
  logic wr_collide;
  logic pend_collide;

  assign wr_ready     = (state_reg == ST_IDLE);
  assign accept       = wr_valid && wr_ready;
  assign wr_in_range  = ({1'b0, wr_row} < ROWS_L);
  assign wr_collide   = (wr_row == rd_row) || (wr_row == alt_row);
  assign pend_collide = (pend_row_reg == rd_row) || (pend_row_reg == alt_row);
  assign wr_err       = wr_err_reg;
  assign clr_busy     = clr_busy_reg;

  // A write accepted alongside clr_start is dropped; the sweep would erase it anyway.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = pend_row_reg;
    mem_wdata = pend_data_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept && wr_in_range && !wr_collide && !clr_start) begin
          mem_we    = 1'b1;
          mem_waddr = wr_row;
          mem_wdata = wr_data;
        end
      end
      ST_PEND: begin
        if (!clr_start && !pend_collide) begin
          mem_we = 1'b1;
        end
      end
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = sweep_reg;
        mem_wdata = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= ST_IDLE;
      pend_row_reg  <= '0;
      pend_data_reg <= '0;
      sweep_reg     <= '0;
      wr_err_reg    <= 1'b0;
      clr_busy_reg  <= 1'b0;
    end else begin
      wr_err_reg <= accept && !wr_in_range;
      case (state_reg)
        ST_IDLE: begin
          if (clr_start) begin
            state_reg    <= ST_CLEAR;
            sweep_reg    <= '0;
            clr_busy_reg <= 1'b1;
          end else if (accept && wr_in_range && wr_collide) begin
            pend_row_reg  <= wr_row;
            pend_data_reg <= wr_data;
            state_reg     <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (clr_start) begin
            state_reg    <= ST_CLEAR;
            sweep_reg    <= '0;
            clr_busy_reg <= 1'b1;
          end else if (!pend_collide) begin
            state_reg <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          if (clr_start) begin
            sweep_reg <= '0;
          end else if (sweep_reg == LAST_ROW) begin
            state_reg    <= ST_IDLE;
            clr_busy_reg <= 1'b0;
          end else begin
            sweep_reg <= sweep_reg + 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/frame_buffer.sv
// ROWS x COLS bit frame store with per-cell read and whole-row writes.
// Define FRAME_BUFFER_ROWREAD_EN to add the registered full-row read port.
module frame_buffer
  import ca_pkg::*;
#(
  parameter int COLS = CA_COLS,
  parameter int ROWS = CA_ROWS,
  localparam int RAW = addr_w(ROWS),
  localparam int CAW = addr_w(COLS)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [RAW-1:0]  rd_row,
  input  logic [CAW-1:0]  rd_col,
  output logic            rd_data,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [RAW-1:0]  wr_row,
  input  logic [COLS-1:0] wr_data,
  output logic            wr_err,
  input  logic            clr_start,
  output logic            clr_busy
`ifdef FRAME_BUFFER_ROWREAD_EN
  ,
  input  logic [RAW-1:0]  rdr_row,
  output logic [COLS-1:0] rdr_data
`endif
);

  localparam logic [RAW:0] ROWS_L = (RAW+1)'(ROWS);
  localparam logic [CAW:0] COLS_L = (CAW+1)'(COLS);

  logic [COLS-1:0] mem [ROWS];

  logic            mem_we;
  logic [RAW-1:0]  mem_waddr;
  logic [COLS-1:0] mem_wdata;
  logic [RAW-1:0]  alt_row;
  logic            rd_ok;

`ifdef FRAME_BUFFER_ROWREAD_EN
  assign alt_row = rdr_row;
`else
  assign alt_row = rd_row;
`endif

  fb_wr_ctrl #(
    .COLS (COLS),
    .ROWS (ROWS),
    .RAW  (RAW)
  ) u_wr_ctrl (
    .clk       (clk),
    .resetn    (resetn),
    .rd_row    (rd_row),
    .alt_row   (alt_row),
    .wr_valid  (wr_valid),
    .wr_row    (wr_row),
    .wr_data   (wr_data),
    .clr_start (clr_start),
    .wr_ready  (wr_ready),
    .wr_err    (wr_err),
    .clr_busy  (clr_busy),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata)
  );

  // Contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign rd_ok = ({1'b0, rd_row} < ROWS_L) && ({1'b0, rd_col} < COLS_L);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_data <= 1'b0;
    end else if (rd_ok) begin
      rd_data <= mem[rd_row][rd_col];
    end else begin
      rd_data <= 1'b0;
    end
  end

`ifdef FRAME_BUFFER_ROWREAD_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdr_data <= '0;
    end else if ({1'b0, rdr_row} < ROWS_L) begin
      rdr_data <= mem[rdr_row];
    end else begin
      rdr_data <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_frame_buffer.sv
// Randomized scoreboard bench for frame_buffer against a behavioural frame model.
module tb_frame_buffer;

  localparam int COLS = 80;
  localparam int ROWS = 60;
  localparam int RAW  = 6;
  localparam int CAW  = 7;

  logic            clk = 1'b0;
  logic            resetn;
  logic [RAW-1:0]  rd_row;
  logic [CAW-1:0]  rd_col;
  logic            rd_data;
  logic            wr_valid;
  logic            wr_ready;
  logic [RAW-1:0]  wr_row;
  logic [COLS-1:0] wr_data;
  logic            wr_err;
  logic            clr_start;
  logic            clr_busy;
`ifdef FRAME_BUFFER_ROWREAD_EN
  logic [RAW-1:0]  rdr_row;
  logic [COLS-1:0] rdr_data;
  assign rdr_row = rd_row;
`endif

  frame_buffer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rd_row    (rd_row),
    .rd_col    (rd_col),
    .rd_data   (rd_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_row    (wr_row),
    .wr_data   (wr_data),
    .wr_err    (wr_err),
    .clr_start (clr_start),
    .clr_busy  (clr_busy)
`ifdef FRAME_BUFFER_ROWREAD_EN
    ,
    .rdr_row   (rdr_row),
    .rdr_data  (rdr_data)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference frame contents and the expectation scoreboard.
  logic [COLS-1:0] model [ROWS];
  int    q_due[$];
  int    q_kind[$];   // 0 rd_data, 1 wr_ready, 2 wr_err, 3 clr_busy
  logic  q_exp[$];
  string q_name[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic void push(input int kind, input string nm, input logic e, input int due);
    q_due.push_back(due);
    q_kind.push_back(kind);
    q_exp.push_back(e);
    q_name.push_back(nm);
  endfunction

  // Monitor: compares every expectation due in the cycle just sampled.
  initial begin
    forever begin
      @(negedge clk);
      begin
        int   i;
        logic act;
        i = 0;
        while (i < q_due.size()) begin
          if (q_due[i] <= cyc) begin
            case (q_kind[i])
              0:       act = rd_data;
              1:       act = wr_ready;
              2:       act = wr_err;
              default: act = clr_busy;
            endcase
            n_cmp++;
            if (q_due[i] < cyc) begin
              n_bad++;
              $display("FAIL %s: expectation expired unchecked (due %0d, now %0d)", q_name[i], q_due[i], cyc);
            end else if (act !== q_exp[i]) begin
              n_bad++;
              $display("FAIL %s: got %0b expected %0b at cycle %0d", q_name[i], act, q_exp[i], cyc);
            end
            q_due.delete(i);
            q_kind.delete(i);
            q_exp.delete(i);
            q_name.delete(i);
          end else begin
            i++;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input int r, input int c, input string nm);
    logic e;
    e = 1'b0;
    if (r < ROWS && c < COLS) e = model[r][c];
    rd_row = RAW'(r);
    rd_col = CAW'(c);
    push(0, nm, e, cyc + 1);
    step();
  endtask

  task automatic do_write(input int r, input logic [COLS-1:0] d, input int rr, input string nm);
    rd_row   = RAW'(rr);
    wr_row   = RAW'(r);
    wr_data  = d;
    wr_valid = 1'b1;
    push(1, {nm, "_ready"}, 1'b1, cyc);
    step();
    wr_valid = 1'b0;
    if (r >= ROWS) begin
      push(2, {nm, "_err"}, 1'b1, cyc);
      push(1, {nm, "_ready_kept"}, 1'b1, cyc);
      step();
      push(2, {nm, "_err_once"}, 1'b0, cyc);
    end else begin
      model[r] = d;
      push(2, {nm, "_no_err"}, 1'b0, cyc);
    end
  endtask

  // Pulses clr_start in the current cycle and follows the sweep. stop_at < ROWS
  // returns while row stop_at is about to be cleared. hold_wr presents a row-10
  // write throughout the sweep, which must wait until the sweep is over.
  task automatic sweep_chk(input string nm, input int stop_at, input bit hold_wr, input logic [COLS-1:0] hd);
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    if (hold_wr) begin
      rd_row   = '0;
      wr_row   = RAW'(10);
      wr_data  = hd;
      wr_valid = 1'b1;
    end
    for (int k = 0; k < ROWS; k++) begin
      if (k == stop_at) return;
      push(3, {nm, "_busy"}, 1'b1, cyc);
      push(1, {nm, "_ready_low"}, 1'b0, cyc);
      step();
      model[k] = '0;
    end
    push(3, {nm, "_busy_done"}, 1'b0, cyc);
    push(1, {nm, "_ready_back"}, 1'b1, cyc);
    if (hold_wr) begin
      step();
      wr_valid  = 1'b0;
      model[10] = hd;
    end
  endtask

  function automatic logic [COLS-1:0] rnd_row();
    return {16'($urandom()), $urandom(), $urandom()};
  endfunction

  initial begin
    logic [COLS-1:0] d;
    int r;
    resetn    = 1'b0;
    rd_row    = '0;
    rd_col    = '0;
    wr_valid  = 1'b0;
    wr_row    = '0;
    wr_data   = '0;
    clr_start = 1'b0;
    step();
    step();
    push(0, "reset_rd_data", 1'b0, cyc);
    push(2, "reset_wr_err", 1'b0, cyc);
    push(3, "reset_clr_busy", 1'b0, cyc);
    step();
    resetn = 1'b1;
    step();
    push(1, "ready_after_reset", 1'b1, cyc);

    // Known starting contents.
    sweep_chk("init_clear", ROWS, 1'b0, '0);

    // Basic write then cell read.
    d = '0;
    d[0] = 1'b1;
    do_write(5, d, 0, "w5");
    read_chk(5, 0, "r5c0_one");
    read_chk(5, 1, "r5c1_zero");

    // Randomized writes (some out of range) and reads, including out-of-range reads.
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 63);
      do_write(r, rnd_row(), (r + 1 + $urandom_range(0, 57)) % ROWS, "rand_wr");
    end
    for (int n = 0; n < 80; n++) begin
      read_chk($urandom_range(0, 63), $urandom_range(0, 127), "rand_rd");
    end

    // Collision: write deferred until the read row moves away.
    rd_row   = RAW'(7);
    rd_col   = CAW'(79);
    wr_row   = RAW'(7);
    wr_data  = '1;
    wr_valid = 1'b1;
    push(1, "col_ready_pre", 1'b1, cyc);
    step();
    wr_valid = 1'b0;
    push(1, "col_ready_low", 1'b0, cyc);
    read_chk(7, 79, "col_old_data");
    push(1, "col_ready_hold", 1'b0, cyc);
    rd_row = RAW'(8);
    rd_col = '0;
    step();
    model[7] = '1;
    push(1, "col_ready_after_commit", 1'b1, cyc);
    read_chk(7, 79, "col_new_data");
    read_chk(7, 0, "col_new_data_c0");

    // Out-of-range row write is dropped.
    do_write(60, rnd_row(), 0, "oor60");
    do_write(63, rnd_row(), 0, "oor63");
    for (int n = 0; n < 20; n++) begin
      read_chk($urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1), "oor_unchanged");
    end

    // Pending write discarded by a clear; a write presented mid-sweep waits.
    do_write(3, '1, 4, "pre3");
    rd_row   = RAW'(3);
    wr_row   = RAW'(3);
    wr_data  = rnd_row();
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    push(1, "pend3_ready_low", 1'b0, cyc);
    step();
    push(1, "pend3_still", 1'b0, cyc);
    d = rnd_row();
    sweep_chk("pend_clear", ROWS, 1'b1, d);
    for (int c = 0; c < COLS; c += 7) read_chk(3, c, "row3_discarded");
    for (int c = 0; c < COLS; c += 9) read_chk(10, c, "row10_waited");

    // Fill, clear, verify every cell.
    for (int rr = 0; rr < ROWS; rr++) do_write(rr, '1, (rr + 1) % ROWS, "fill");
    sweep_chk("full_clear", ROWS, 1'b0, '0);
    for (int rr = 0; rr < ROWS; rr++)
      for (int c = 0; c < COLS; c++) read_chk(rr, c, "all_zero");

    // Reset in the middle of a sweep.
    for (int rr = 0; rr < ROWS; rr++) do_write(rr, '1, (rr + 1) % ROWS, "fill2");
    read_chk(40, 5, "pre_rst_row40");
    sweep_chk("rst_sweep", 30, 1'b0, '0);
    resetn = 1'b0;
    push(0, "midrst_rd_data", 1'b0, cyc);
    push(3, "midrst_clr_busy", 1'b0, cyc);
    push(2, "midrst_wr_err", 1'b0, cyc);
    step();
    step();
    resetn = 1'b1;
    step();
    push(1, "midrst_ready", 1'b1, cyc);
    push(0, "midrst_row40_again", 1'b1, cyc);
    push(3, "midrst_busy_stays", 1'b0, cyc);
    read_chk(29, 11, "row29_cleared");
    read_chk(30, 11, "row30_kept");
    for (int c = 0; c < COLS; c += 5) read_chk(40, c, "row40_kept");
    for (int n = 0; n < 20; n++) begin
      read_chk($urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1), "post_rst_rd");
    end

    step();
    step();
    for (int i = 0; i < q_due.size(); i++) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: never compared, expected %0b", q_name[i], q_exp[i]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
